io_request_unit: RTL and testbench
==================================

IO_REQUEST_UNIT -- requirements
Module: io_request_unit

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 1024, meaning bus-wait cycles before a request is abandoned; legal range 2..2^20.
REQ-002 SHALL have parameter CntWidth, default 16, meaning width of the saturating timeout-event counter.
REQ-003 i_clk  in  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 i_req_valid  in  1  CPU presents an IO request.
REQ-006 o_req_ready  out  1  unit accepts a request this cycle.
REQ-007 i_req_is_out  in  1  1 = out (write) instruction, 0 = in (read) instruction.
REQ-008 i_req_dev_id  in  32  target device id.
REQ-009 i_req_wdata  in  32  write data for out requests.
REQ-010 o_resp_valid  out  1  response available to CPU.
REQ-011 i_resp_ready  in  1  CPU consumes response.
REQ-012 o_resp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-013 o_resp_timeout  out  1  request ended by timeout, not handshake.
REQ-014 o_dev_id  out  32  device id driven to the IO bus.
REQ-015 if_bus_wr  Decoupled.sender  32  write channel into the IO bus (bus din).
REQ-016 if_bus_rd  Decoupled.receiver  32  read channel from the IO bus (bus dout).
REQ-017 o_timeout_count  out  CntWidth  number of timed-out requests since reset, saturating.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, READ, RESP.
REQ-019 o_req_ready SHALL be 1 exactly when state is IDLE; a request is accepted on i_req_valid & o_req_ready.
REQ-020 On acceptance SHALL register dev_id, wdata, is_out; next state WRITE if is_out else READ.
REQ-021 o_dev_id SHALL be driven only from the registered dev_id and SHALL stay stable from the WRITE/READ cycle until the following IDLE.
REQ-022 In WRITE: if_bus_wr.valid=1, if_bus_wr.bits=registered wdata, if_bus_rd.ready=0; no other state asserts if_bus_wr.valid.
REQ-023 In READ: if_bus_rd.ready=1, if_bus_wr.valid=0; no other state asserts if_bus_rd.ready.
REQ-024 Bus valid/ready outputs SHALL be registered-state-derived only (no combinational path from if_bus_*.ready/valid), since the bus decodes direction from them.
REQ-025 WRITE -> RESP on if_bus_wr.ready=1; rdata=0, timeout=0.
REQ-026 READ -> RESP on if_bus_rd.valid=1; capture if_bus_rd.bits into rdata, timeout=0.
REQ-027 Wait counter SHALL clear on entering WRITE/READ and increment each cycle without handshake; when it equals TimeoutCycles-1 and no handshake that cycle -> RESP with timeout=1, rdata=0.
REQ-028 Handshake in the same cycle the counter reaches its limit SHALL win (normal completion, timeout=0).
REQ-029 On each timeout o_timeout_count SHALL increment by 1, saturating at 2^CntWidth-1.
REQ-030 In RESP: o_resp_valid=1 with stable rdata/timeout until i_resp_ready=1, then IDLE; i_resp_ready outside RESP is ignored.
REQ-031 Minimum latency: accept cycle N, bus handshake cycle N+1, o_resp_valid in N+2; next request accepted no earlier than cycle after response consumed.
REQ-032 i_req_* changes while not in IDLE SHALL have no effect.

Reset
REQ-033 While i_rst=0, asynchronously: state=IDLE, o_req_ready=1, o_resp_valid=0, o_resp_rdata=0, o_resp_timeout=0, o_dev_id=0, if_bus_wr.valid=0, if_bus_wr.bits=0, if_bus_rd.ready=0, o_timeout_count=0, wait counter=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it with no response and no counter increment; the first cycle after release is IDLE.

Verification
REQ-035 Write: req is_out=1 dev_id=0x4 wdata=0xA5, bus wr.ready=1 immediately -> wr.valid one cycle with bits 0xA5, o_dev_id=0x4, resp_valid at N+2, rdata=0, timeout=0.
REQ-036 Read with stall: req is_out=0 dev_id=0x0, rd.valid after 5 cycles with bits 0x41 -> rd.ready held 6 cycles, resp rdata=0x41, timeout=0, o_dev_id stable throughout.
REQ-037 Timeout: TimeoutCycles=8, read with rd.valid never 1 -> resp after exactly 8 READ cycles, timeout=1, rdata=0, o_timeout_count 0->1.
REQ-038 Boundary: TimeoutCycles=8, rd.valid=1 first in 8th READ cycle with 0x1234 -> timeout=0, rdata=0x1234, counter unchanged.
REQ-039 Backpressure: resp_ready low 4 cycles with i_req_valid=1 and new dev_id -> resp held stable, req_ready=0, o_dev_id unchanged, no bus activity.
REQ-040 Reset mid-WRITE: i_rst=0 during WRITE -> wr.valid drops asynchronously, no response, next accepted request completes normally; CntWidth=2 with 5 timeouts -> o_timeout_count=3.

Source files
------------

// File: rtl/io_request_unit.sv
// io_request_unit: serialises CPU in/out instructions onto a decoupled IO bus.
// One request is in flight at a time. The bus decodes the transfer direction
// from wr_valid/rd_ready, so both are decoded from the state register only.
// A bus wait that runs for TimeoutCycles cycles is abandoned. The response
// then carries timeout=1, and a saturating event counter is bumped.
module io_request_unit #(
  parameter int TimeoutCycles = 1024,
  parameter int CntWidth      = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_is_out,
  input  logic [31:0]         i_req_dev_id,
  input  logic [31:0]         i_req_wdata,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [31:0]         o_resp_rdata,
  output logic                o_resp_timeout,
  output logic [31:0]         o_dev_id,
  output logic                if_bus_wr_valid,
  input  logic                if_bus_wr_ready,
  output logic [31:0]         if_bus_wr_bits,
  input  logic                if_bus_rd_valid,
  output logic                if_bus_rd_ready,
  input  logic [31:0]         if_bus_rd_bits,
  output logic [CntWidth-1:0] o_timeout_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int              WW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WW-1:0]   LIMIT = WW'(TimeoutCycles - 1);

  typedef struct packed {
    logic [31:0] rdata;
    logic        timeout;
  } resp_t;

  logic [1:0]          state;
  logic [31:0]         dev_id_q;
  logic [31:0]         wdata_q;
  logic [WW-1:0]       wait_cnt;
  logic [CntWidth-1:0] tmo_cnt;
  resp_t               resp_q;
  logic                wait_hit;

  assign wait_hit = (wait_cnt == LIMIT);

  // The direction of a request lives in the WRITE/READ state itself.
  // Every bus-facing strobe is a pure decode of that state register.
  assign o_req_ready     = (state == IDLE);
  assign o_resp_valid    = (state == RESP);
  assign if_bus_wr_valid = (state == WRITE);
  assign if_bus_rd_ready = (state == READ);
  assign if_bus_wr_bits  = wdata_q;
  assign o_dev_id        = dev_id_q;
  assign o_resp_rdata    = resp_q.rdata;
  assign o_resp_timeout  = resp_q.timeout;
  assign o_timeout_count = tmo_cnt;

  // Request FSM: accept, then wait on the bus with a timeout, then hold the response.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      dev_id_q <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
      resp_q   <= '0;
    end else begin
      case (state)
        IDLE: if (i_req_valid) begin
          dev_id_q <= i_req_dev_id;
          wdata_q  <= i_req_wdata;
          wait_cnt <= '0;
          state    <= i_req_is_out ? WRITE : READ;
        end
        WRITE, READ: begin
          // A handshake in the limit cycle still completes normally.
          if ((state == WRITE) ? if_bus_wr_ready : if_bus_rd_valid) begin
            resp_q.rdata   <= (state == READ) ? if_bus_rd_bits : 32'h0;
            resp_q.timeout <= 1'b0;
            state          <= RESP;
          end else if (wait_hit) begin
            resp_q.rdata   <= 32'h0;
            resp_q.timeout <= 1'b1;
            if (!(&tmo_cnt)) tmo_cnt <= tmo_cnt + 1'b1;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: if (i_resp_ready) state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_request_unit.sv
// Directed bench for io_request_unit (TimeoutCycles=8, CntWidth=2).
// Inputs are driven and outputs sampled on the falling edge. Every loop has a fixed count.
module tb_io_request_unit;
  logic        clk, rst;
  logic        req_valid, req_ready, req_is_out;
  logic [31:0] req_dev_id, req_wdata;
  logic        resp_valid, resp_ready, resp_timeout;
  logic [31:0] resp_rdata, dev_id;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [31:0] wr_bits, rd_bits;
  logic [1:0]  tmo_count;

  int n_tests = 0;
  int n_fail  = 0;

  io_request_unit #(.TimeoutCycles(8), .CntWidth(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_is_out(req_is_out), .i_req_dev_id(req_dev_id), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_timeout(resp_timeout),
    .o_dev_id(dev_id),
    .if_bus_wr_valid(wr_valid), .if_bus_wr_ready(wr_ready), .if_bus_wr_bits(wr_bits),
    .if_bus_rd_valid(rd_valid), .if_bus_rd_ready(rd_ready), .if_bus_rd_bits(rd_bits),
    .o_timeout_count(tmo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one request for a single cycle. Return at the first WRITE/READ cycle.
  task automatic start_req(input logic is_out, input logic [31:0] dev, input logic [31:0] wd);
    req_valid = 1'b1; req_is_out = is_out; req_dev_id = dev; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Consume a response that is being presented. Check the unit returns to idle.
  task automatic consume(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_idle_ready"}, req_ready, 1);
    chk({tag, "_idle_noresp"}, resp_valid, 0);
  endtask

  // A read whose bus never answers. The response must appear after exactly 8 READ cycles.
  task automatic do_timeout(input string tag, input logic [31:0] dev, input logic [1:0] exp_cnt);
    start_req(1'b0, dev, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_rd_ready"}, rd_ready, 1);
      chk({tag, "_noresp"}, resp_valid, 0);
      step();
    end
    chk({tag, "_resp_valid"}, resp_valid, 1);
    chk({tag, "_timeout"}, resp_timeout, 1);
    chk({tag, "_rdata"}, resp_rdata, 0);
    chk({tag, "_count"}, tmo_count, exp_cnt);
    consume(tag);
  endtask

  initial begin
    rst = 1'b0; req_valid = 0; req_is_out = 0; req_dev_id = 0; req_wdata = 0;
    resp_ready = 0; wr_ready = 0; rd_valid = 0; rd_bits = 0;
    step(); step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_timeout", resp_timeout, 0);
    chk("rst_dev_id", dev_id, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_bits", wr_bits, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_count", tmo_count, 0);
    rst = 1'b1;
    step();

    // Write with an immediate bus handshake. The response arrives at N+2.
    wr_ready = 1'b1;
    start_req(1'b1, 32'h4, 32'hA5);
    chk("wr_valid", wr_valid, 1);
    chk("wr_bits", wr_bits, 32'hA5);
    chk("wr_dev_id", dev_id, 32'h4);
    chk("wr_rd_ready", rd_ready, 0);
    chk("wr_req_ready", req_ready, 0);
    step();
    wr_ready = 1'b0;
    chk("wr_resp_valid", resp_valid, 1);
    chk("wr_rdata", resp_rdata, 0);
    chk("wr_timeout", resp_timeout, 0);
    chk("wr_valid_drop", wr_valid, 0);
    consume("wr");

    // Read that stalls for 5 cycles. rd_ready is held for 6 cycles.
    start_req(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("rds_rd_ready", rd_ready, 1);
      chk("rds_wr_valid", wr_valid, 0);
      chk("rds_dev_id", dev_id, 0);
      chk("rds_noresp", resp_valid, 0);
      if (i == 5) begin rd_valid = 1'b1; rd_bits = 32'h41; end
      step();
    end
    rd_valid = 1'b0; rd_bits = 32'h0;
    chk("rds_resp_valid", resp_valid, 1);
    chk("rds_rdata", resp_rdata, 32'h41);
    chk("rds_timeout", resp_timeout, 0);
    chk("rds_rd_ready_drop", rd_ready, 0);
    consume("rds");

    // Timeout on a read that gets no answer. The counter goes 0 -> 1.
    chk("tmo_count_pre", tmo_count, 0);
    do_timeout("tmo", 32'h7, 2'd1);

    // The handshake arrives in the 8th READ cycle and beats the timeout.
    start_req(1'b0, 32'h3, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("bnd_rd_ready", rd_ready, 1);
      if (i == 7) begin rd_valid = 1'b1; rd_bits = 32'h1234; end
      step();
    end
    rd_valid = 1'b0; rd_bits = 32'h0;
    chk("bnd_resp_valid", resp_valid, 1);
    chk("bnd_timeout", resp_timeout, 0);
    chk("bnd_rdata", resp_rdata, 32'h1234);
    chk("bnd_count", tmo_count, 1);
    consume("bnd");

    // Backpressure: the response is held while a new request is waiting.
    rd_valid = 1'b1; rd_bits = 32'hBEEF;
    start_req(1'b0, 32'h10, 32'h0);
    step();
    rd_valid = 1'b0; rd_bits = 32'h0;
    req_valid = 1'b1; req_is_out = 1'b1; req_dev_id = 32'h99; req_wdata = 32'h77;
    for (int i = 0; i < 4; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_rdata", resp_rdata, 32'hBEEF);
      chk("bp_timeout", resp_timeout, 0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_dev_id", dev_id, 32'h10);
      chk("bp_bus_idle", {wr_valid, rd_ready}, 0);
      step();
    end
    req_valid = 1'b0;
    consume("bp");

    // Reset during WRITE abandons the transfer. wr_valid drops without a clock edge.
    start_req(1'b1, 32'h20, 32'h5A);
    chk("rw_wr_valid", wr_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("rw_async_wr_valid", wr_valid, 0);
    chk("rw_async_resp", resp_valid, 0);
    chk("rw_async_dev_id", dev_id, 0);
    chk("rw_async_count", tmo_count, 0);
    step();
    rst = 1'b1;
    step();
    chk("rw_post_idle", req_ready, 1);
    chk("rw_post_noresp", resp_valid, 0);
    wr_ready = 1'b1;
    start_req(1'b1, 32'h21, 32'hC3);
    chk("rw2_wr_bits", wr_bits, 32'hC3);
    chk("rw2_dev_id", dev_id, 32'h21);
    step();
    wr_ready = 1'b0;
    chk("rw2_resp_valid", resp_valid, 1);
    chk("rw2_timeout", resp_timeout, 0);
    consume("rw2");

    // Five timeouts on a 2-bit counter. The count saturates at 3.
    do_timeout("sat1", 32'h1, 2'd1);
    do_timeout("sat2", 32'h2, 2'd2);
    do_timeout("sat3", 32'h3, 2'd3);
    do_timeout("sat4", 32'h4, 2'd3);
    do_timeout("sat5", 32'h5, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
